// File: rtl/reg_file_sb_if.sv
// Bus bundle for reg_file_sb: two read ports, one write port, reservation and flush.
interface reg_file_sb_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] raddr1;
    logic [ADDR_WIDTH-1:0] raddr2;
    logic [DATA_WIDTH-1:0] rdata1;
    logic [DATA_WIDTH-1:0] rdata2;
    logic                  rbusy1;
    logic                  rbusy2;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  resv_en;
    logic [ADDR_WIDTH-1:0] resv_addr;
    logic                  resv_ok;
    logic                  flush;
    logic [ADDR_WIDTH:0]   busy_cnt;

    modport master (
        output raddr1, raddr2, wen, waddr, wdata, resv_en, resv_addr, flush,
        input  rdata1, rdata2, rbusy1, rbusy2, resv_ok, busy_cnt
    );

    modport slave (
        input  raddr1, raddr2, wen, waddr, wdata, resv_en, resv_addr, flush,
        output rdata1, rdata2, rbusy1, rbusy2, resv_ok, busy_cnt
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard, two combinational read ports and one write port.
// Optional same-cycle write-to-read forwarding is enabled by defining REG_FILE_SB_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;
    logic [DEPTH-1:0]      busy_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;

    logic wr_hit;
    logic resv_set;
    logic wr_clr;
    logic resv_ok_c;

    // Register 0 is excluded from writes and reservations so it stays zero and never busy.
    assign wr_hit    = bus.wen && (bus.waddr != '0);
    assign resv_ok_c = (bus.resv_addr == '0) || !busy[bus.resv_addr];
    assign resv_set  = bus.resv_en && resv_ok_c && (bus.resv_addr != '0) && !bus.flush;
    // A write only retires a busy bit the same-cycle reservation is not re-setting.
    assign wr_clr    = wr_hit && busy[bus.waddr] && !(resv_set && (bus.resv_addr == bus.waddr));

    always_comb begin
        busy_nxt = busy;
        cnt_nxt  = cnt;
        if (bus.flush) begin
            busy_nxt = '0;
            cnt_nxt  = '0;
        end else begin
            if (wr_hit)   busy_nxt[bus.waddr]     = 1'b0;
            if (resv_set) busy_nxt[bus.resv_addr] = 1'b1;
            cnt_nxt = cnt + CNT_W'(resv_set) - CNT_W'(wr_clr);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
            busy <= '0;
            cnt  <= '0;
        end else begin
            if (wr_hit) regs[bus.waddr] <= bus.wdata;
            busy <= busy_nxt;
            cnt  <= cnt_nxt;
        end
    end

    // Read ports; with forwarding, an in-flight write to the same address is visible now.
    always_comb begin
        bus.rdata1 = regs[bus.raddr1];
        bus.rbusy1 = busy[bus.raddr1];
        bus.rdata2 = regs[bus.raddr2];
        bus.rbusy2 = busy[bus.raddr2];
`ifdef REG_FILE_SB_BYPASS_EN
        if (!rst && wr_hit && (bus.waddr == bus.raddr1)) begin
            bus.rdata1 = bus.wdata;
            bus.rbusy1 = 1'b0;
        end
        if (!rst && wr_hit && (bus.waddr == bus.raddr2)) begin
            bus.rdata2 = bus.wdata;
            bus.rbusy2 = 1'b0;
        end
`else
`endif
    end

    assign bus.resv_ok  = resv_ok_c;
    assign bus.busy_cnt = cnt;
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed vectors with literal expectations plus a
// per-cycle comparison against an array/popcount model of the register file.
module tb_reg_file_sb;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic run = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reg_file_sb_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bif ();

    reg_file_sb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] m_regs [N];
    bit            m_busy [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_pop();
        int n = 0;
        for (int i = 0; i < int'(N); i++) if (m_busy[i]) n++;
        return n;
    endfunction

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
`ifdef REG_FILE_SB_BYPASS_EN
        if (bif.wen && bif.waddr != 0 && bif.waddr == a) return bif.wdata;
`endif
        return (a == 0) ? '0 : m_regs[a];
    endfunction

    function automatic logic exp_rb(input logic [AW-1:0] a);
`ifdef REG_FILE_SB_BYPASS_EN
        if (bif.wen && bif.waddr != 0 && bif.waddr == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    // Model: write clears busy, accepted reservation then sets it, flush clears everything.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(N); i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        end else begin
            automatic bit ok = (bif.resv_addr == 0) || !m_busy[bif.resv_addr];
            if (bif.wen && bif.waddr != 0) begin
                m_regs[bif.waddr] = bif.wdata;
                m_busy[bif.waddr] = 1'b0;
            end
            if (bif.resv_en && ok && bif.resv_addr != 0) m_busy[bif.resv_addr] = 1'b1;
            if (bif.flush) for (int i = 0; i < int'(N); i++) m_busy[i] = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (run && !rst) begin
            chk("rdata1", 64'(bif.rdata1), 64'(exp_rd(bif.raddr1)));
            chk("rdata2", 64'(bif.rdata2), 64'(exp_rd(bif.raddr2)));
            chk("rbusy1", 64'(bif.rbusy1), 64'(exp_rb(bif.raddr1)));
            chk("rbusy2", 64'(bif.rbusy2), 64'(exp_rb(bif.raddr2)));
            chk("resv_ok", 64'(bif.resv_ok),
                64'((bif.resv_addr == 0) || !m_busy[bif.resv_addr]));
            chk("busy_cnt", 64'(bif.busy_cnt), 64'(m_pop()));
        end
    end

    task automatic idle();
        bif.wen = 1'b0; bif.waddr = '0; bif.wdata = '0;
        bif.resv_en = 1'b0; bif.resv_addr = '0; bif.flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < int'(N); i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
        bif.raddr1 = '0; bif.raddr2 = '0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        chk("reset_rdata1", 64'(bif.rdata1), 64'h0);
        chk("reset_resv_ok", 64'(bif.resv_ok), 64'h1);
        chk("reset_cnt", 64'(bif.busy_cnt), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b1;
        tick();

        // Write r5, attempt write to r0
        bif.wen = 1'b1; bif.waddr = 5'd5; bif.wdata = 32'hDEADBEEF;
        tick();
        bif.waddr = 5'd0; bif.wdata = 32'h1234;
        bif.raddr1 = 5'd5; bif.raddr2 = 5'd0;
        tick();
        idle();
        #1;
        chk("r5_lit", 64'(bif.rdata1), 64'hDEADBEEF);
        chk("r0_lit", 64'(bif.rdata2), 64'h0);

        // Reserve r3, duplicate reservation, then retire by write
        bif.resv_en = 1'b1; bif.resv_addr = 5'd3; bif.raddr1 = 5'd3;
        tick();
        chk("r3_busy_lit", 64'(bif.rbusy1), 64'h1);
        chk("r3_cnt_lit", 64'(bif.busy_cnt), 64'h1);
        chk("r3_ok_lit", 64'(bif.resv_ok), 64'h0);
        tick();
        chk("r3_dup_cnt_lit", 64'(bif.busy_cnt), 64'h1);
        idle();
        bif.wen = 1'b1; bif.waddr = 5'd3; bif.wdata = 32'd7;
        tick();
        idle();
        #1;
        chk("r3_clr_busy_lit", 64'(bif.rbusy1), 64'h0);
        chk("r3_clr_cnt_lit", 64'(bif.busy_cnt), 64'h0);
        chk("r3_data_lit", 64'(bif.rdata1), 64'h7);

        // Write and reserve r4 together: reservation wins
        bif.wen = 1'b1; bif.waddr = 5'd4; bif.wdata = 32'h55;
        bif.resv_en = 1'b1; bif.resv_addr = 5'd4; bif.raddr2 = 5'd4;
        tick();
        idle();
        #1;
        chk("r4_data_lit", 64'(bif.rdata2), 64'h55);
        chk("r4_busy_lit", 64'(bif.rbusy2), 64'h1);
        chk("r4_cnt_lit", 64'(bif.busy_cnt), 64'h1);

        // Write and reserve different registers; then reserve r1, r2, r7
        bif.wen = 1'b1; bif.waddr = 5'd4; bif.wdata = 32'h66;
        bif.resv_en = 1'b1; bif.resv_addr = 5'd1;
        tick();
        idle();
        bif.resv_en = 1'b1; bif.resv_addr = 5'd2; tick();
        bif.resv_addr = 5'd7; tick();
        idle();
        #1;
        chk("pre_flush_cnt_lit", 64'(bif.busy_cnt), 64'h3);

        // Flush while reserving r9 and writing r10
        bif.flush = 1'b1; bif.resv_en = 1'b1; bif.resv_addr = 5'd9;
        bif.wen = 1'b1; bif.waddr = 5'd10; bif.wdata = 32'h77;
        tick();
        idle();
        bif.raddr1 = 5'd9; bif.raddr2 = 5'd10;
        #1;
        chk("flush_cnt_lit", 64'(bif.busy_cnt), 64'h0);
        chk("flush_r9_lit", 64'(bif.rbusy1), 64'h0);
        chk("flush_wr_lit", 64'(bif.rdata2), 64'h77);
        bif.raddr1 = 5'd5; bif.raddr2 = 5'd7;
        #1;
        chk("flush_data_lit", 64'(bif.rdata1), 64'hDEADBEEF);
        chk("flush_r7_lit", 64'(bif.rbusy2), 64'h0);

        // Same-cycle write/read of r6
        bif.raddr1 = 5'd6;
        bif.wen = 1'b1; bif.waddr = 5'd6; bif.wdata = 32'hA5A5A5A5;
        #1;
`ifdef REG_FILE_SB_BYPASS_EN
        chk("r6_same_lit", 64'(bif.rdata1), 64'hA5A5A5A5);
`else
        chk("r6_same_lit", 64'(bif.rdata1), 64'h0);
`endif
        tick();
        idle();
        #1;
        chk("r6_next_lit", 64'(bif.rdata1), 64'hA5A5A5A5);

        // Reserve every register, counter saturates at N-1; r0 reservation is a no-op
        for (int i = 1; i < int'(N); i++) begin
            bif.resv_en = 1'b1; bif.resv_addr = AW'(i);
            tick();
        end
        bif.resv_addr = '0;
        tick();
        idle();
        #1;
        chk("full_cnt_lit", 64'(bif.busy_cnt), 64'(N - 1));
        bif.flush = 1'b1;
        tick();
        idle();

        // Deterministic mixed traffic
        for (int i = 0; i < 300; i++) begin
            bif.wen       = ((i % 3) != 0);
            bif.waddr     = AW'((i * 7) % 11);
            bif.wdata     = DW'(i * 32'h01010101 + 3);
            bif.resv_en   = ((i % 4) != 1);
            bif.resv_addr = AW'((i * 5 + 2) % 13);
            bif.flush     = ((i % 37) == 36);
            bif.raddr1    = AW'((i * 3) % 13);
            bif.raddr2    = AW'((i * 7) % 11);
            tick();
        end
        idle();

        // Asynchronous reset mid-cycle with r8 busy and holding 0x99
        bif.wen = 1'b1; bif.waddr = 5'd8; bif.wdata = 32'h99;
        bif.resv_en = 1'b1; bif.resv_addr = 5'd8;
        tick();
        idle();
        bif.raddr1 = 5'd8; bif.raddr2 = 5'd8;
        #1;
        chk("r8_data_lit", 64'(bif.rdata1), 64'h99);
        chk("r8_busy_lit", 64'(bif.rbusy1), 64'h1);
        bif.resv_en = 1'b1; bif.resv_addr = 5'd4;
        rst = 1'b1;
        #1;
        chk("arst_rdata_lit", 64'(bif.rdata1), 64'h0);
        chk("arst_rbusy_lit", 64'(bif.rbusy2), 64'h0);
        chk("arst_cnt_lit", 64'(bif.busy_cnt), 64'h0);
        chk("arst_ok_lit", 64'(bif.resv_ok), 64'h1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        bif.raddr1 = 5'd4;
        tick();
        chk("post_rst_cnt_lit", 64'(bif.busy_cnt), 64'h0);
        chk("post_rst_r4_lit", 64'(bif.rbusy1), 64'h0);
        tick();

        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
